// File: rtl/data_access_ctrl.sv
// Data-memory access controller: load hit/miss refill, write-through stores, timeout trap.
// Optional load-miss counter enabled by defining DATA_ACCESS_PERF_CNT_EN.
module data_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemWrite,
  input  logic [1:0]  ResultSrc,
  input  logic        Hit,
  input  logic        Ready,
  output logic        MemRead,
  output logic        MemWriteReq,
  output logic        Refill,
  output logic        Stall,
  output logic        Error,
  output logic [15:0] MissCount
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS_WAIT  = 3'd1,
    WRITE_WAIT = 3'd2,
    DONE       = 3'd3,
    ERR        = 3'd4
  } state_t;

  // Last counter value a wait state may show; without Ready the next edge would reach the limit.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       held_load;
  logic       is_store;
  logic       is_load;
  logic       in_wait;
  logic       at_limit;
  logic       rd;
  logic       wr;
  logic       fill;
  logic       stl;
  logic       err;

  assign is_store = MemWrite;
  assign is_load  = !MemWrite && (ResultSrc == 2'b01);
  assign in_wait  = (state == MISS_WAIT) || (state == WRITE_WAIT);
  assign at_limit = (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter and record of whether the pending instruction is a load
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt  <= 8'd0;
      held_load <= 1'b0;
    end else begin
      if (in_wait && !Ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (state == IDLE) begin
        held_load <= is_load;
      end else begin
        held_load <= held_load;
      end
    end
  end

  // Next-state and request decode
  always_comb begin
    state_next = state;
    rd         = 1'b0;
    wr         = 1'b0;
    fill       = 1'b0;
    stl        = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (is_store) begin
          wr         = 1'b1;
          stl        = 1'b1;
          state_next = WRITE_WAIT;
        end else if (is_load) begin
          rd = 1'b1;
          if (!Hit) begin
            stl        = 1'b1;
            fill       = 1'b1;
            state_next = MISS_WAIT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      MISS_WAIT: begin
        stl  = 1'b1;
        fill = 1'b1;
        if (Ready) begin
          state_next = DONE;
        end else if (at_limit) begin
          state_next = ERR;
        end else begin
          state_next = MISS_WAIT;
        end
      end
      WRITE_WAIT: begin
        stl = 1'b1;
        wr  = 1'b1;
        if (Ready) begin
          state_next = DONE;
        end else if (at_limit) begin
          state_next = ERR;
        end else begin
          state_next = WRITE_WAIT;
        end
      end
      DONE: begin
        rd         = held_load;
        state_next = IDLE;
      end
      ERR: begin
        stl        = 1'b1;
        err        = 1'b1;
        state_next = ERR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // While reset is held only the load read-enable may pass through.
  assign MemRead     = rd;
  assign MemWriteReq = wr   & RST;
  assign Refill      = fill & RST;
  assign Stall       = stl  & RST;
  assign Error       = err  & RST;

`ifdef DATA_ACCESS_PERF_CNT_EN
  logic [15:0] miss_cnt;

  // Saturating count of IDLE to MISS_WAIT transitions
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      miss_cnt <= 16'h0000;
    end else if ((state == IDLE) && is_load && !Hit && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'h0001;
    end else begin
      miss_cnt <= miss_cnt;
    end
  end

  assign MissCount = miss_cnt;
`else
  assign MissCount = 16'h0000;
`endif

endmodule
